// File: rtl/irq_pending_ctrl_if.sv
// ----------------------------------------------------------------------------
// irq_pending_ctrl_if
// Bundles the request, mask, acknowledge and status signals of the interrupt
// pending controller.
//   master : the system side; drives requests, mask writes, ack and eoi.
//   slave  : the controller; returns pend_out, irq, active and active_id.
// Signals:
//   req_in[7:0]    request lines (bit 7 highest priority downstream)
//   mask_wr        mask write strobe
//   mask_in[7:0]   mask value, 1 = masked
//   ack            acknowledge pulse
//   ack_id[2:0]    index being acknowledged (from the downstream encoder)
//   eoi            end-of-interrupt pulse
//   pend_out[7:0]  pending & ~mask, feeds the downstream priority encoder
//   irq            registered interrupt request
//   active         a request is in service
//   active_id[2:0] index of the in-service request, valid while active = 1
// ----------------------------------------------------------------------------
interface irq_pending_ctrl_if;
  logic [7:0] req_in;
  logic       mask_wr;
  logic [7:0] mask_in;
  logic       ack;
  logic [2:0] ack_id;
  logic       eoi;
  logic [7:0] pend_out;
  logic       irq;
  logic       active;
  logic [2:0] active_id;

  modport master (
    output req_in, mask_wr, mask_in, ack, ack_id, eoi,
    input  pend_out, irq, active, active_id
  );

  modport slave (
    input  req_in, mask_wr, mask_in, ack, ack_id, eoi,
    output pend_out, irq, active, active_id
  );
endinterface

// File: rtl/irq_pending_ctrl.sv
// ----------------------------------------------------------------------------
// irq_pending_ctrl
// Latches interrupt requests into a pending register, presents the unmasked
// pending set to a downstream priority encoder, and runs a small
// IDLE -> REQ -> SVC handshake with the servicing agent (ack, then eoi).
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : irq_pending_ctrl_if.slave (requests, mask, ack/eoi, status)
// Configuration:
//   IRQ_LEVEL_TRIG_EN : when defined, a request line sets its pending bit on
//                       every cycle it is high (level mode); otherwise only a
//                       rising edge sets it (edge mode, default).
// ----------------------------------------------------------------------------
module irq_pending_ctrl (
  input  logic                clk,
  input  logic                rst_n,
  irq_pending_ctrl_if.slave   bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_SVC  = 2'd2
  } state_e;

  state_e     state_q, state_d;
  logic [7:0] req_prev_q;
  logic [7:0] pending_q, pending_d;
  logic [7:0] mask_q, mask_d;
  logic [2:0] active_id_q, active_id_d;
  logic       irq_q, active_q;

  logic [7:0] pend_vis;
  logic [7:0] set_vec;
  logic [7:0] clr_vec;
  logic       accept;

  // Unmasked pending set; purely combinational from the registers.
  assign pend_vis     = pending_q & ~mask_q;
  assign bus.pend_out = pend_vis;

`ifdef IRQ_LEVEL_TRIG_EN
  assign set_vec = bus.req_in;
`else
  assign set_vec = bus.req_in & ~req_prev_q;
`endif

  // An ack is only honoured while requesting and only for a visible bit.
  assign accept = (state_q == ST_REQ) && bus.ack && pend_vis[bus.ack_id];

  // NOTE: every signal assigned in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    clr_vec = '0;
    if (accept) clr_vec[bus.ack_id] = 1'b1;
  end

  // Set is applied after clear so a same-cycle new request wins over an ack.
  // Masked bits still latch; the mask only gates visibility.
  assign pending_d = (pending_q & ~clr_vec) | set_vec;
  assign mask_d    = bus.mask_wr ? bus.mask_in : mask_q;

  always_comb begin
    state_d     = state_q;
    active_id_d = active_id_q;
    case (state_q)
      ST_IDLE: begin
        if (|pend_vis) state_d = ST_REQ;
      end
      ST_REQ: begin
        if (accept) begin
          state_d     = ST_SVC;
          active_id_d = bus.ack_id;
        end else if (pend_vis == 8'h00) begin
          // Everything visible was masked away before any ack.
          state_d = ST_IDLE;
        end
      end
      ST_SVC: begin
        if (bus.eoi) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: state uses non-blocking assignments so every flop samples the
  // pre-edge values regardless of statement order.
  // NOTE: the reset clears all state, including the in-service record, so a
  // reset mid-service needs no eoi.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      req_prev_q  <= 8'h00;
      pending_q   <= 8'h00;
      mask_q      <= 8'h00;
      active_id_q <= 3'd0;
      irq_q       <= 1'b0;
      active_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      req_prev_q  <= bus.req_in;
      pending_q   <= pending_d;
      mask_q      <= mask_d;
      active_id_q <= active_id_d;
      // Outputs registered from the next state so they track it exactly.
      irq_q       <= (state_d == ST_REQ);
      active_q    <= (state_d == ST_SVC);
    end
  end

  assign bus.irq       = irq_q;
  assign bus.active    = active_q;
  assign bus.active_id = active_id_q;

endmodule

// File: tb/tb_irq_pending_ctrl.sv
// ----------------------------------------------------------------------------
// tb_irq_pending_ctrl
// Directed scenarios with fixed expectations plus a randomized run checked
// against a behavioural model of the pending/request/service rules.
// ----------------------------------------------------------------------------
module tb_irq_pending_ctrl;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  irq_pending_ctrl_if bus ();

  irq_pending_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model: pending set, last request sample, mask, and whether
  // an interrupt is being requested or serviced.
  logic [7:0] m_pend, m_prev, m_mask;
  logic [2:0] m_id;
  bit         m_irq, m_svc;

  function automatic void model_reset();
    m_pend = 8'h00; m_prev = 8'h00; m_mask = 8'h00;
    m_id = 3'd0; m_irq = 1'b0; m_svc = 1'b0;
  endfunction

  function automatic void model_step(input logic [7:0] req, input logic mw,
                                     input logic [7:0] mi, input logic a,
                                     input logic [2:0] aid, input logic e);
    logic [7:0] vis, nxt;
    bit taken;
    vis   = m_pend & ~m_mask;
    taken = m_irq && a && vis[aid];
    nxt   = m_pend;
    if (taken) nxt[aid] = 1'b0;
    for (int i = 0; i < 8; i++) begin
`ifdef IRQ_LEVEL_TRIG_EN
      if (req[i]) nxt[i] = 1'b1;
`else
      if (req[i] && !m_prev[i]) nxt[i] = 1'b1;
`endif
    end
    if (taken) begin
      m_svc = 1'b1; m_irq = 1'b0; m_id = aid;
    end else if (m_irq) begin
      if (vis == 8'h00) m_irq = 1'b0;
    end else if (m_svc) begin
      if (e) m_svc = 1'b0;
    end else if (vis != 8'h00) begin
      m_irq = 1'b1;
    end
    m_prev = req;
    if (mw) m_mask = mi;
    m_pend = nxt;
  endfunction

  // One clock: drive inputs, take the edge, advance the model, settle 1 ns.
  task automatic tick(input logic [7:0] req, input logic mw, input logic [7:0] mi,
                      input logic a, input logic [2:0] aid, input logic e);
    bus.req_in  = req;
    bus.mask_wr = mw;
    bus.mask_in = mi;
    bus.ack     = a;
    bus.ack_id  = aid;
    bus.eoi     = e;
    @(posedge clk);
    model_step(req, mw, mi, a, aid, e);
    #1;
    bus.mask_wr = 1'b0;
    bus.ack     = 1'b0;
    bus.eoi     = 1'b0;
  endtask

  task automatic do_reset(input logic [7:0] req_during);
    bus.req_in = req_during; bus.mask_wr = 1'b0; bus.mask_in = 8'h00;
    bus.ack = 1'b0; bus.ack_id = 3'd0; bus.eoi = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    model_reset();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    bus.req_in = 8'h10; bus.mask_wr = 1'b0; bus.mask_in = 8'h00;
    bus.ack = 1'b0; bus.ack_id = 3'd0; bus.eoi = 1'b0;
    rst_n = 1'b0;
    #3;
    checks++; if (bus.pend_out !== 8'h00) begin errors++; $display("FAIL reset_pend: got %h expected %h", bus.pend_out, 8'h00); end
    checks++; if (bus.irq !== 1'b0) begin errors++; $display("FAIL reset_irq: got %b expected 0", bus.irq); end
    checks++; if (bus.active !== 1'b0) begin errors++; $display("FAIL reset_active: got %b expected 0", bus.active); end
    checks++; if (bus.active_id !== 3'd0) begin errors++; $display("FAIL reset_active_id: got %0d expected 0", bus.active_id); end
    @(negedge clk);
    model_reset();
    rst_n = 1'b1;
    // A line already high at release counts as an edge on the first clock.
    tick(8'h10, 0, 8'h00, 0, 3'd0, 0);
    checks++; if (bus.pend_out !== 8'h10) begin errors++; $display("FAIL reset_release_edge: got %h expected %h", bus.pend_out, 8'h10); end
  endtask

  task automatic test_single();
    do_reset(8'h00);
    tick(8'h04, 0, 8'h00, 0, 3'd0, 0);
    checks++; if (bus.pend_out !== 8'h04) begin errors++; $display("FAIL single_pend: got %h expected %h", bus.pend_out, 8'h04); end
    checks++; if (bus.irq !== 1'b0) begin errors++; $display("FAIL single_irq_latency: got %b expected 0", bus.irq); end
    tick(8'h00, 0, 8'h00, 0, 3'd0, 0);
    checks++; if (bus.irq !== 1'b1) begin errors++; $display("FAIL single_irq: got %b expected 1", bus.irq); end
    tick(8'h00, 0, 8'h00, 1, 3'd2, 0);
    checks++; if (bus.pend_out !== 8'h00) begin errors++; $display("FAIL single_ack_pend: got %h expected %h", bus.pend_out, 8'h00); end
    checks++; if (bus.active !== 1'b1) begin errors++; $display("FAIL single_active: got %b expected 1", bus.active); end
    checks++; if (bus.active_id !== 3'd2) begin errors++; $display("FAIL single_active_id: got %0d expected 2", bus.active_id); end
    checks++; if (bus.irq !== 1'b0) begin errors++; $display("FAIL single_irq_svc: got %b expected 0", bus.irq); end
    tick(8'h00, 0, 8'h00, 0, 3'd0, 1);
    checks++; if (bus.active !== 1'b0) begin errors++; $display("FAIL single_eoi_active: got %b expected 0", bus.active); end
    tick(8'h00, 0, 8'h00, 0, 3'd0, 0);
    checks++; if (bus.irq !== 1'b0) begin errors++; $display("FAIL single_irq_after_eoi: got %b expected 0", bus.irq); end
  endtask

  task automatic test_priority_pair();
    do_reset(8'h00);
    tick(8'hC0, 0, 8'h00, 0, 3'd0, 0);
    checks++; if (bus.pend_out !== 8'hC0) begin errors++; $display("FAIL pair_pend: got %h expected %h", bus.pend_out, 8'hC0); end
    tick(8'h00, 0, 8'h00, 0, 3'd0, 0);
    tick(8'h00, 0, 8'h00, 1, 3'd7, 0);
    checks++; if (bus.pend_out !== 8'h40) begin errors++; $display("FAIL pair_ack7_pend: got %h expected %h", bus.pend_out, 8'h40); end
    checks++; if (bus.active_id !== 3'd7) begin errors++; $display("FAIL pair_active_id7: got %0d expected 7", bus.active_id); end
    tick(8'h00, 0, 8'h00, 0, 3'd0, 1);
    checks++; if (bus.irq !== 1'b0) begin errors++; $display("FAIL pair_irq_at_eoi: got %b expected 0", bus.irq); end
    tick(8'h00, 0, 8'h00, 0, 3'd0, 0);
    checks++; if (bus.irq !== 1'b1) begin errors++; $display("FAIL pair_irq_again: got %b expected 1", bus.irq); end
    tick(8'h00, 0, 8'h00, 1, 3'd6, 0);
    checks++; if (bus.pend_out !== 8'h00) begin errors++; $display("FAIL pair_ack6_pend: got %h expected %h", bus.pend_out, 8'h00); end
    checks++; if (bus.active_id !== 3'd6) begin errors++; $display("FAIL pair_active_id6: got %0d expected 6", bus.active_id); end
  endtask

  task automatic test_mask();
    do_reset(8'h00);
    tick(8'h00, 1, 8'hFF, 0, 3'd0, 0);
    tick(8'h01, 0, 8'h00, 0, 3'd0, 0);
    checks++; if (bus.pend_out !== 8'h00) begin errors++; $display("FAIL mask_hidden_pend: got %h expected %h", bus.pend_out, 8'h00); end
    tick(8'h00, 0, 8'h00, 0, 3'd0, 0);
    checks++; if (bus.irq !== 1'b0) begin errors++; $display("FAIL mask_hidden_irq: got %b expected 0", bus.irq); end
    tick(8'h00, 1, 8'h00, 0, 3'd0, 0);
    checks++; if (bus.pend_out !== 8'h01) begin errors++; $display("FAIL mask_unmask_pend: got %h expected %h", bus.pend_out, 8'h01); end
    tick(8'h00, 0, 8'h00, 0, 3'd0, 0);
    checks++; if (bus.irq !== 1'b1) begin errors++; $display("FAIL mask_unmask_irq: got %b expected 1", bus.irq); end
  endtask

  task automatic test_mask_retract();
    do_reset(8'h00);
    tick(8'h08, 0, 8'h00, 0, 3'd0, 0);
    tick(8'h00, 0, 8'h00, 0, 3'd0, 0);
    checks++; if (bus.irq !== 1'b1) begin errors++; $display("FAIL retract_irq_on: got %b expected 1", bus.irq); end
    tick(8'h00, 1, 8'h08, 0, 3'd0, 0);
    checks++; if (bus.pend_out !== 8'h00) begin errors++; $display("FAIL retract_pend: got %h expected %h", bus.pend_out, 8'h00); end
    tick(8'h00, 0, 8'h00, 1, 3'd3, 0);
    checks++; if (bus.irq !== 1'b0) begin errors++; $display("FAIL retract_irq_off: got %b expected 0", bus.irq); end
    checks++; if (bus.active !== 1'b0) begin errors++; $display("FAIL retract_ack_ignored: got %b expected 0", bus.active); end
    tick(8'h00, 1, 8'h00, 0, 3'd0, 0);
    checks++; if (bus.pend_out !== 8'h08) begin errors++; $display("FAIL retract_still_pending: got %h expected %h", bus.pend_out, 8'h08); end
  endtask

  task automatic test_set_wins();
    do_reset(8'h00);
    tick(8'h20, 0, 8'h00, 0, 3'd0, 0);
    tick(8'h00, 0, 8'h00, 0, 3'd0, 0);
    tick(8'h20, 0, 8'h00, 1, 3'd5, 0);
    checks++; if (bus.pend_out !== 8'h20) begin errors++; $display("FAIL setwins_pend: got %h expected %h", bus.pend_out, 8'h20); end
    checks++; if (bus.active_id !== 3'd5) begin errors++; $display("FAIL setwins_active_id: got %0d expected 5", bus.active_id); end
    tick(8'h00, 0, 8'h00, 0, 3'd0, 1);
    tick(8'h00, 0, 8'h00, 0, 3'd0, 0);
    checks++; if (bus.irq !== 1'b1) begin errors++; $display("FAIL setwins_reassert: got %b expected 1", bus.irq); end
  endtask

  task automatic test_level_vs_edge();
    logic [7:0] exp_pend;
`ifdef IRQ_LEVEL_TRIG_EN
    exp_pend = 8'h01;
`else
    exp_pend = 8'h00;
`endif
    do_reset(8'h00);
    tick(8'h01, 0, 8'h00, 0, 3'd0, 0);
    tick(8'h01, 0, 8'h00, 0, 3'd0, 0);
    tick(8'h01, 0, 8'h00, 1, 3'd0, 0);
    tick(8'h01, 0, 8'h00, 0, 3'd0, 0);
    checks++; if (bus.pend_out !== exp_pend) begin errors++; $display("FAIL held_line_after_ack: got %h expected %h", bus.pend_out, exp_pend); end
  endtask

  task automatic test_reset_mid_service();
    do_reset(8'h00);
    tick(8'h06, 0, 8'h00, 0, 3'd0, 0);
    tick(8'h00, 0, 8'h00, 0, 3'd0, 0);
    tick(8'h00, 0, 8'h00, 1, 3'd1, 0);
    checks++; if (bus.active !== 1'b1) begin errors++; $display("FAIL midsvc_active: got %b expected 1", bus.active); end
    rst_n = 1'b0;
    #2;
    checks++; if (bus.active !== 1'b0) begin errors++; $display("FAIL midsvc_async_active: got %b expected 0", bus.active); end
    checks++; if (bus.pend_out !== 8'h00) begin errors++; $display("FAIL midsvc_async_pend: got %h expected %h", bus.pend_out, 8'h00); end
    do_reset(8'h00);
    tick(8'h00, 0, 8'h00, 0, 3'd0, 0);
    tick(8'h00, 0, 8'h00, 0, 3'd0, 0);
    checks++; if (bus.irq !== 1'b0) begin errors++; $display("FAIL midsvc_irq_after: got %b expected 0", bus.irq); end
  endtask

  task automatic test_random();
    logic [7:0] req, mi, vis;
    logic       mw, a, e;
    logic [2:0] aid;
    do_reset(8'h00);
    req = 8'h00;
    for (int n = 0; n < 400; n++) begin
      req = req ^ (8'($urandom) & 8'($urandom) & 8'($urandom));
      mw  = ($urandom_range(15, 0) == 0);
      mi  = 8'($urandom) & 8'($urandom);
      a   = ($urandom_range(2, 0) == 0);
      e   = ($urandom_range(3, 0) == 0);
      vis = m_pend & ~m_mask;
      aid = 3'($urandom_range(7, 0));
      if ($urandom_range(1, 0) == 1) begin
        for (int b = 0; b < 8; b++) if (vis[b]) aid = 3'(b);
      end
      tick(req, mw, mi, a, aid, e);
      checks++; if (bus.pend_out !== (m_pend & ~m_mask)) begin errors++; $display("FAIL rand_pend cycle %0d: got %h expected %h", n, bus.pend_out, m_pend & ~m_mask); end
      checks++; if (bus.irq !== m_irq) begin errors++; $display("FAIL rand_irq cycle %0d: got %b expected %b", n, bus.irq, m_irq); end
      checks++; if (bus.active !== m_svc) begin errors++; $display("FAIL rand_active cycle %0d: got %b expected %b", n, bus.active, m_svc); end
      if (m_svc) begin
        checks++; if (bus.active_id !== m_id) begin errors++; $display("FAIL rand_active_id cycle %0d: got %0d expected %0d", n, bus.active_id, m_id); end
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    checks = 0;
    errors = 0;
    model_reset();
    test_reset();
    test_single();
    test_priority_pair();
    test_mask();
    test_mask_retract();
    test_set_wins();
    test_level_vs_edge();
    test_reset_mid_service();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/irq_pending_ctrl.md
IRQ_PENDING_CTRL -- requirements
Module: irq_pending_ctrl

Interface
REQ-001 clk  input  1  rising-edge clock for all state.
REQ-002 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-003 req_in  input  8  request lines, synchronous to clk; bit 7 is highest priority downstream.
REQ-004 mask_wr  input  1  mask write strobe.
REQ-005 mask_in  input  8  mask value; 1 = masked.
REQ-006 ack  input  1  acknowledge pulse from the servicing agent.
REQ-007 ack_id  input  3  index being acknowledged, sourced from the downstream 8-to-3 priority encoder output.
REQ-008 eoi  input  1  end-of-interrupt pulse.
REQ-009 pend_out  output  8  pending & ~mask; drives the downstream priority encoder d input.
REQ-010 irq  output  1  interrupt request, registered.
REQ-011 active  output  1  a request is in service.
REQ-012 active_id  output  3  index of the in-service request; valid while active=1.

Function
REQ-013 The block SHALL hold registers req_prev[7:0], pending[7:0], mask[7:0], state, and active_id.
REQ-014 pend_out SHALL be combinational: pending & ~mask, with no added latency.
REQ-015 Edge mode: pending[i] SHALL set on the clock edge where req_in[i]=1 and req_prev[i]=0, and req_prev SHALL load req_in every cycle.
REQ-016 mask_wr=1 SHALL load mask_in into mask on that edge; a masked bit SHALL still latch into pending.
REQ-017 The FSM SHALL have states IDLE, REQ, and SVC.
REQ-018 IDLE->REQ SHALL occur when |pend_out=1; irq SHALL be 1 exactly while the state is REQ, with 1-cycle latency from pending set to irq.
REQ-019 In REQ, ack=1 with pend_out[ack_id]=1 SHALL clear pending[ack_id], load active_id=ack_id, and move to SVC.
REQ-020 In REQ, ack=1 with pend_out[ack_id]=0 SHALL be ignored; the state SHALL stay REQ.
REQ-021 In REQ, if pend_out becomes 0 through a mask write, the FSM SHALL return to IDLE with no ack; irq SHALL drop next cycle.
REQ-022 In SVC, active SHALL be 1; eoi=1 SHALL move the FSM to IDLE and clear active.
REQ-023 ack in IDLE or SVC and eoi in IDLE or REQ SHALL be ignored.
REQ-024 If a new edge set and an ack clear hit the same bit in one cycle, the set SHALL win.
REQ-025 New edges SHALL keep latching during SVC; after eoi the FSM SHALL re-enter REQ one cycle later if pend_out!=0.
REQ-026 A repeat edge on an already-pending bit SHALL be absorbed, with no count kept.

Reset
REQ-027 rst_n=0 SHALL force, asynchronously, pending=0, req_prev=0, mask=8'h00, state=IDLE, irq=0, active=0, active_id=0.
REQ-028 A req_in line high at reset release SHALL register as an edge on the first clock.
REQ-029 Reset mid-service SHALL discard the in-service and pending state with no eoi required.

Configuration
REQ-030 Macro IRQ_LEVEL_TRIG_EN: when defined, pending[i] SHALL set whenever req_in[i]=1 (level mode), so an acked bit re-sets next cycle if the line is still high.
REQ-031 When IRQ_LEVEL_TRIG_EN is undefined, edge mode per REQ-015 SHALL apply.

Verification
REQ-032 Reset, then pulse req_in=8'b00000100 for 1 cycle -> pend_out=8'b00000100 next edge; irq=1 one cycle later; ack with ack_id=2 -> pend_out=0, active=1, active_id=2; eoi -> active=0, irq stays 0.
REQ-033 req_in edges 8'b11000000 -> pend_out=8'hC0 (encoder y=7); ack id 7 -> pend_out=8'h40, active_id=7; eoi -> irq=1 again one cycle later; ack id 6 -> pend_out=0.
REQ-034 mask=8'hFF, edge on bit 0 -> pend_out=0, irq=0; mask write 8'h00 -> pend_out=8'h01, irq=1.
REQ-035 While in REQ on bit 3, write mask=8'h08 -> pend_out=0, FSM to IDLE, irq=0; ack id 3 in the following cycle is ignored.
REQ-036 Same cycle: ack id 5 and a new rising edge on bit 5 -> pending[5] stays 1, active_id=5.
REQ-037 With IRQ_LEVEL_TRIG_EN, hold req_in=8'b00000001 and ack id 0 -> pending[0]=1 again next cycle; without the macro -> pending[0]=0.
